// File: rtl/dma_periph_pkg.sv
// Shared constants for the DMA peripheral responder: FSM state encodings and err bit positions.
package dma_periph_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQUEST  = 2'd1;
  localparam logic [1:0] ST_SERVICE  = 2'd2;
  localparam logic [1:0] ST_TERMINAL = 2'd3;

  localparam int ERR_UNDERRUN = 0;
  localparam int ERR_OVERRUN  = 1;

endpackage

// File: rtl/dma_periph_fifo.sv
// Synchronous first-word-fall-through FIFO; the head word is visible on pop_data whenever not empty.
module dma_periph_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;
  logic              do_push;
  logic              do_pop;

  assign full     = (count_reg == FULL_COUNT);
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  // Storage is not reset: pointers and count define which entries are live.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/dma_peripheral_responder.sv
// Peripheral endpoint of an 8237-style DMA channel, buffering words between a local stream and the DMA bus.
// Optional feature macro DMA_PERIPH_EOP_EN adds per-word last flags (in_last) and a device-driven EOP_N_out.
module dma_peripheral_responder
  import dma_periph_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int CHANNEL = 0,
  parameter int THRESH  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              dir,
  output logic              DREQ,
  input  logic [3:0]        DACK,
  input  logic              IOR_N,
  input  logic              IOW_N,
  input  logic              EOP_N,
  input  logic [DATA_W-1:0] DB_in,
  output logic [DATA_W-1:0] DB_out,
  output logic              DB_oe,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              tc_pulse,
  output logic [1:0]        err
`ifdef DMA_PERIPH_EOP_EN
  ,
  input  logic              in_last,
  output logic              EOP_N_out
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT  = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH_CNT  = (AW+1)'(THRESH);
`ifdef DMA_PERIPH_EOP_EN
  localparam int FIFO_W = DATA_W + 1;
`else
  localparam int FIFO_W = DATA_W;
`endif

  logic [1:0]        state_reg;
  logic              dreq_reg;
  logic              tc_reg;
  logic [1:0]        err_reg;
  logic              dir_q;
  logic              ior_n_reg;
  logic              iow_low_reg;
  logic [DATA_W-1:0] db_hold_reg;

  logic              ack;
  logic              rd_active;
  logic              wr_active;
  logic              rd_pop_req;
  logic              wr_push_req;
  logic              local_push;
  logic              local_pop;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AW:0]       fifo_count;
  logic [AW:0]       fifo_free;
  logic [FIFO_W-1:0] fifo_wdata;
  logic [FIFO_W-1:0] fifo_rdata;
  logic [DATA_W-1:0] head_data;
  logic              head_last;
  logic              last_read;
  logic              eop_event;
  logic              start_req;
  logic              unused_dack;

  // Other DACK bits belong to sibling devices on the same controller.
  assign unused_dack = ^DACK;

  assign ack         = DACK[CHANNEL];
  assign rd_active   = ack && !IOR_N && !dir_q;
  assign wr_active   = ack && !IOW_N && dir_q;
  assign rd_pop_req  = rd_active && ior_n_reg;
  assign wr_push_req = iow_low_reg && IOW_N;

  assign in_ready    = !fifo_full && !dir_q;
  assign out_valid   = !fifo_empty && dir_q;
  assign local_push  = in_valid && in_ready;
  assign local_pop   = out_valid && out_ready;
  assign fifo_push   = dir_q ? wr_push_req : local_push;
  assign fifo_pop    = dir_q ? local_pop : rd_pop_req;
  assign fifo_free   = FULL_COUNT - fifo_count;

`ifdef DMA_PERIPH_EOP_EN
  assign fifo_wdata = dir_q ? {1'b0, db_hold_reg} : {in_last, in_data};
  assign head_data  = fifo_rdata[DATA_W-1:0];
  assign head_last  = fifo_rdata[DATA_W];
  assign EOP_N_out  = !last_read;
`else
  assign fifo_wdata = dir_q ? db_hold_reg : in_data;
  assign head_data  = fifo_rdata;
  assign head_last  = 1'b0;
`endif

  assign last_read = rd_active && !fifo_empty && head_last;
  assign eop_event = ack && (!EOP_N || last_read);
  assign start_req = dir ? (fifo_free >= THRESH_CNT) : (fifo_count >= THRESH_CNT);

  assign DB_oe    = rd_active;
  assign DB_out   = (rd_active && !fifo_empty) ? head_data : '0;
  assign out_data = head_data;
  assign DREQ     = dreq_reg;
  assign tc_pulse = tc_reg;
  assign err      = err_reg;

  dma_periph_fifo #(
    .DATA_W (FIFO_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg   <= ST_IDLE;
      dreq_reg    <= 1'b0;
      tc_reg      <= 1'b0;
      err_reg     <= 2'b00;
      dir_q       <= 1'b0;
      ior_n_reg   <= 1'b1;
      iow_low_reg <= 1'b0;
      db_hold_reg <= '0;
    end else begin
      ior_n_reg   <= IOR_N;
      iow_low_reg <= wr_active;
      if (wr_active) db_hold_reg <= DB_in;
      if (rd_pop_req && fifo_empty)  err_reg[ERR_UNDERRUN] <= 1'b1;
      if (wr_push_req && fifo_full)  err_reg[ERR_OVERRUN]  <= 1'b1;
      tc_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          dreq_reg <= 1'b0;
          if (start_req) begin
            state_reg <= ST_REQUEST;
            dreq_reg  <= 1'b1;
            dir_q     <= dir;
          end
        end
        ST_REQUEST: begin
          dreq_reg <= 1'b1;
          if (ack) state_reg <= ST_SERVICE;
        end
        ST_SERVICE: begin
          if (eop_event) begin
            state_reg <= ST_TERMINAL;
            dreq_reg  <= 1'b0;
            tc_reg    <= 1'b1;
          end else if (!ack) begin
            state_reg <= ST_IDLE;
            dreq_reg  <= 1'b0;
          end else begin
            // Demand mode: keep requesting while there is anything left to move.
            dreq_reg <= dir_q ? (fifo_free != '0) : (fifo_count != '0);
          end
        end
        default: begin
          dreq_reg <= 1'b0;
          if (!ack) state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_peripheral_responder.sv
// Scoreboard bench for dma_peripheral_responder; the EOP section is built only with DMA_PERIPH_EOP_EN.
`timescale 1ns/1ps
module tb_dma_peripheral_responder;
  import dma_periph_pkg::*;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       dir = 1'b0;
  logic       DREQ;
  logic [3:0] DACK = 4'b0000;
  logic       IOR_N = 1'b1;
  logic       IOW_N = 1'b1;
  logic       EOP_N = 1'b1;
  logic [7:0] DB_in = 8'h00;
  logic [7:0] DB_out;
  logic       DB_oe;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       tc_pulse;
  logic [1:0] err;
`ifdef DMA_PERIPH_EOP_EN
  logic       in_last = 1'b0;
  logic       EOP_N_out;
`endif

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_rd[$];
  logic [7:0] exp_out[$];

  dma_peripheral_responder #(
    .DATA_W (8), .DEPTH (8), .CHANNEL (0), .THRESH (4)
  ) dut (
    .CLK (CLK), .RESET (RESET), .dir (dir), .DREQ (DREQ), .DACK (DACK),
    .IOR_N (IOR_N), .IOW_N (IOW_N), .EOP_N (EOP_N), .DB_in (DB_in),
    .DB_out (DB_out), .DB_oe (DB_oe), .in_valid (in_valid), .in_ready (in_ready),
    .in_data (in_data), .out_valid (out_valid), .out_ready (out_ready),
    .out_data (out_data), .tc_pulse (tc_pulse), .err (err)
`ifdef DMA_PERIPH_EOP_EN
    , .in_last (in_last), .EOP_N_out (EOP_N_out)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_local(input logic [7:0] d);
    in_valid = 1'b1; in_data = d; tick(); in_valid = 1'b0;
  endtask

  task automatic dma_read(input logic [7:0] e);
    exp_rd.push_back(e);
    IOR_N = 1'b0; tick(); IOR_N = 1'b1; tick();
  endtask

  task automatic dma_write(input logic [7:0] d);
    DB_in = d; IOW_N = 1'b0; tick();
    IOW_N = 1'b1; DB_in = ~d; tick();
  endtask

  // Monitor: every bus read and every local pop is matched against the scoreboard.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (DB_oe) begin
        if (exp_rd.size() == 0) begin
          checks++;
          $display("FAIL unexpected_read: DB_out=%h, no read expected", DB_out);
        end else begin
          $display("dma read  DB_out=%h expected=%h", DB_out, exp_rd[0]);
          check("db_out", 32'(DB_out), 32'(exp_rd.pop_front()));
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          checks++;
          $display("FAIL unexpected_out: out_data=%h, no word expected", out_data);
        end else begin
          $display("local pop out_data=%h expected=%h", out_data, exp_out[0]);
          check("out_data", 32'(out_data), 32'(exp_out.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(2);
    check("rst_dreq", 32'(DREQ), 0);
    check("rst_db_oe", 32'(DB_oe), 0);
    check("rst_db_out", 32'(DB_out), 0);
    check("rst_tc", 32'(tc_pulse), 0);
    check("rst_err", 32'(err), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
`ifdef DMA_PERIPH_EOP_EN
    check("rst_eop_out", 32'(EOP_N_out), 1);
`endif
    RESET = 1'b0;
    tick();

    // Device->memory: fill to threshold, four reads, then one underrun read.
    for (int i = 0; i < 4; i++) push_local(8'hA0 + 8'(i));
    check("dreq_before_thresh", 32'(DREQ), 0);
    tick();
    check("dreq_at_thresh", 32'(DREQ), 1);
    DACK = 4'b0001; tick();
    for (int i = 0; i < 4; i++) begin
      dma_read(8'hA0 + 8'(i));
      if (i == 2) check("dreq_held", 32'(DREQ), 1);
    end
    check("dreq_drained", 32'(DREQ), 0);
    dma_read(8'h00);
    check("err_underrun", 32'(err), 32'h1);
    DACK = 4'b0000; tick();
    check("idle_after_read", 32'(dut.state_reg), 32'(ST_IDLE));

    // Controller terminal count on the second of four reads.
    for (int i = 0; i < 4; i++) push_local(8'hB0 + 8'(i));
    tick();
    DACK = 4'b0001; tick();
    dma_read(8'hB0);
    exp_rd.push_back(8'hB1);
    IOR_N = 1'b0; EOP_N = 1'b0; tick();
    check("tc_pulse_on", 32'(tc_pulse), 1);
    check("dreq_terminal", 32'(DREQ), 0);
    IOR_N = 1'b1; EOP_N = 1'b1; tick();
    check("tc_pulse_off", 32'(tc_pulse), 0);
    DACK = 4'b0000; tick();
    check("idle_after_tc", 32'(dut.state_reg), 32'(ST_IDLE));
    check("count_after_tc", 32'(dut.fifo_count), 2);

    // Acknowledge for another channel: strobes must be ignored.
    push_local(8'hC0); push_local(8'hC1);
    tick();
    check("dreq_req2", 32'(DREQ), 1);
    DACK = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      IOR_N = 1'b0; #1;
      check("wrong_ch_db_oe", 32'(DB_oe), 0);
      tick(); IOR_N = 1'b1; tick();
    end
    check("wrong_ch_count", 32'(dut.fifo_count), 4);
    check("wrong_ch_dreq", 32'(DREQ), 1);

    // Mid-service dir change is ignored, then reset mid-service.
    DACK = 4'b0001; tick();
    dma_read(8'hB2);
    dir = 1'b1; tick();
    check("dir_ignored_in_ready", 32'(in_ready), 1);
    check("dir_ignored_out_valid", 32'(out_valid), 0);
    check("svc_count3", 32'(dut.fifo_count), 3);
    check("err_sticky", 32'(err), 32'h1);
    RESET = 1'b1; #1;
    check("rst_mid_dreq", 32'(DREQ), 0);
    check("rst_mid_count", 32'(dut.fifo_count), 0);
    check("rst_mid_err", 32'(err), 0);
    DACK = 4'b0000;
    tick();
    RESET = 1'b0;

    // Memory->device: two words streamed out, then fill to overrun.
    tick();
    check("dreq_dir1", 32'(DREQ), 1);
    check("in_ready_dir1", 32'(in_ready), 0);
    DACK = 4'b0001; tick();
    out_ready = 1'b1;
    exp_out.push_back(8'h5A); dma_write(8'h5A);
    exp_out.push_back(8'hA5); dma_write(8'hA5);
    tick(2);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) dma_write(8'h10 + 8'(i));
    tick();
    check("dreq_full", 32'(DREQ), 0);
    check("err_before_ovr", 32'(err), 0);
    dma_write(8'hFF);
    check("err_overrun", 32'(err), 32'h2);
    check("count_full", 32'(dut.fifo_count), 8);
    for (int i = 0; i < 8; i++) exp_out.push_back(8'h10 + 8'(i));
    out_ready = 1'b1; tick(10);
    out_ready = 1'b0;
    DACK = 4'b0000; tick();

`ifdef DMA_PERIPH_EOP_EN
    // Device-tagged last word ends the transfer.
    RESET = 1'b1; dir = 1'b0; tick(); RESET = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      in_last = (i == 2);
      push_local(8'hD0 + 8'(i));
    end
    in_last = 1'b0;
    tick();
    DACK = 4'b0001; tick();
    dma_read(8'hD0);
    dma_read(8'hD1);
    exp_rd.push_back(8'hD2);
    IOR_N = 1'b0; #1;
    check("eop_out_low", 32'(EOP_N_out), 0);
    tick();
    check("eop_tc_pulse", 32'(tc_pulse), 1);
    check("eop_terminal", 32'(dut.state_reg), 32'(ST_TERMINAL));
    IOR_N = 1'b1; tick();
    check("eop_out_high", 32'(EOP_N_out), 1);
    DACK = 4'b0000; tick();
`endif

    check("rd_queue_empty", 32'(exp_rd.size()), 0);
    check("out_queue_empty", 32'(exp_out.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
